// File: rtl/sfx_pkg.sv
// Package sfx_pkg: shared types and constants for the sound-effect tone generator.
//   - FSM state enum (IDLE, PLAY, GAP)
//   - trig_code encodings
//   - per-note phase increments, note lengths and gap length (in AC97 frames)
//   - default square-wave amplitude
//   - note_lookup(): maps (effect code, note index) to the note's parameters
// Optional build macro used by the top: SFX_DECAY_EN (stepped amplitude decay).
package sfx_pkg;

  localparam int SAMPLE_W = 20;  // AC97 slot width
  localparam int PHASE_W  = 16;  // f = inc * 48000 / 2^PHASE_W
  localparam int CNT_W    = 13;  // frame counter, longest note 8191 frames

  localparam logic [SAMPLE_W-1:0] DEF_AMPLITUDE = 20'h20000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sfx_state_t;

  typedef enum logic [1:0] {
    CODE_NONE   = 2'd0,
    CODE_PADDLE = 2'd1,
    CODE_BRICK  = 2'd2,
    CODE_LIFE   = 2'd3
  } sfx_code_t;

  localparam logic [PHASE_W-1:0] INC_PADDLE = 16'd1202;  // 880 Hz
  localparam logic [PHASE_W-1:0] INC_BRICK  = 16'd1802;  // 1320 Hz
  localparam logic [PHASE_W-1:0] INC_LIFE_0 = 16'd601;   // 440 Hz
  localparam logic [PHASE_W-1:0] INC_LIFE_1 = 16'd300;   // 220 Hz

  localparam logic [CNT_W-1:0] FRAMES_PADDLE = 13'd1920;
  localparam logic [CNT_W-1:0] FRAMES_BRICK  = 13'd1440;
  localparam logic [CNT_W-1:0] FRAMES_LIFE   = 13'd5760;
  localparam logic [CNT_W-1:0] GAP_FRAMES    = 13'd960;
  localparam logic [CNT_W-1:0] GAP_LAST      = GAP_FRAMES - 13'd1;

  typedef struct packed {
    logic [PHASE_W-1:0] inc;
    logic [CNT_W-1:0]   frames;
    logic               last;    // final note of the effect
  } note_t;

  function automatic note_t note_lookup(input logic [1:0] code, input logic note_idx);
    note_t n;
    n.inc    = '0;
    n.frames = 13'd1;
    n.last   = 1'b1;
    case (code)
      CODE_PADDLE: begin
        n.inc    = INC_PADDLE;
        n.frames = FRAMES_PADDLE;
      end
      CODE_BRICK: begin
        n.inc    = INC_BRICK;
        n.frames = FRAMES_BRICK;
      end
      CODE_LIFE: begin
        n.frames = FRAMES_LIFE;
        n.inc    = note_idx ? INC_LIFE_1 : INC_LIFE_0;
        n.last   = note_idx;
      end
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sfx_ready_sync.sv
// sfx_ready_sync: brings the asynchronous AC97 ready strobe into system_clock
// through a 2-flop synchroniser and emits one-cycle pulse per rising edge.
// Ports:
//   system_clock  in  system clock
//   reset         in  synchronous active-high reset
//   i_ready       in  AC97 frame strobe (bit-clock domain)
//   o_frame_tick  out one system_clock pulse per AC97 frame
module sfx_ready_sync (
  input  logic system_clock,
  input  logic reset,
  input  logic i_ready,
  output logic o_frame_tick
);

  logic r_sync_meta;
  logic r_sync;
  logic r_sync_prev;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync_meta <= i_ready;
      r_sync      <= r_sync_meta;
      r_sync_prev <= r_sync;
    end
  end

  // Combinational edge detect so the tick lands in the cycle right after the
  // second synchroniser flop; the consumer's output register is the third stage.
  assign o_frame_tick = r_sync & ~r_sync_prev;

endmodule

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: square-wave sound-effect sample source feeding the AC97 link.
// One sample per AC97 frame, paced by the resynchronised codec ready strobe.
// Ports:
//   system_clock    in   system clock
//   reset           in   synchronous active-high reset
//   ready           in   AC97 frame strobe (asynchronous)
//   trig_valid      in   one-cycle effect request strobe
//   trig_code       in   0 none, 1 paddle hit, 2 brick break, 3 life lost
//   left_out_data   out  20-bit two's-complement sample
//   right_out_data  out  same sample as left
//   sample_strobe   out  one-cycle pulse when outputs update
//   busy            out  high while an effect is playing
// Build option: define SFX_DECAY_EN for a stepped amplitude decay within each note.
module sfx_tone_gen
  import sfx_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] AMPLITUDE = DEF_AMPLITUDE
) (
  input  logic                system_clock,
  input  logic                reset,
  input  logic                ready,
  input  logic                trig_valid,
  input  logic [1:0]          trig_code,
  output logic [SAMPLE_W-1:0] left_out_data,
  output logic [SAMPLE_W-1:0] right_out_data,
  output logic                sample_strobe,
  output logic                busy
);

  sfx_state_t          r_state, w_state_next;
  logic [PHASE_W-1:0]  r_phase, w_phase_next;
  logic [CNT_W-1:0]    r_frame_cnt, w_frame_cnt_next;
  logic                r_note_idx, w_note_idx_next;
  logic [1:0]          r_cur_code, w_cur_code_next;
  logic [SAMPLE_W-1:0] r_sample, w_sample_next;
  logic                r_strobe, w_strobe_next;

  logic                w_frame_tick;
  logic                w_accept;
  note_t               w_note;
  logic [SAMPLE_W-1:0] w_mag;
  logic [SAMPLE_W-1:0] w_mag_neg;

  sfx_ready_sync u_ready_sync (
    .system_clock (system_clock),
    .reset        (reset),
    .i_ready      (ready),
    .o_frame_tick (w_frame_tick)
  );

  // Preemption: only a strictly higher-priority code interrupts a playing effect.
  assign w_accept = trig_valid && (trig_code != CODE_NONE) &&
                    ((r_state == IDLE) || (trig_code > r_cur_code));

  assign w_note = note_lookup(r_cur_code, r_note_idx);

`ifdef SFX_DECAY_EN
  // Halve the magnitude every 1024 frames of the current note.
  assign w_mag = AMPLITUDE >> r_frame_cnt[CNT_W-1:CNT_W-3];
`else
  assign w_mag = AMPLITUDE;
`endif

  // Plain two's-complement negate; magnitude is always below 2^(SAMPLE_W-1).
  assign w_mag_neg = (~w_mag) + SAMPLE_W'(1);

  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_frame_cnt <= '0;
      r_note_idx  <= 1'b0;
      r_cur_code  <= CODE_NONE;
      r_sample    <= '0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_note_idx  <= w_note_idx_next;
      r_cur_code  <= w_cur_code_next;
      r_sample    <= w_sample_next;
      r_strobe    <= w_strobe_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_frame_cnt_next = r_frame_cnt;
    w_note_idx_next  = r_note_idx;
    w_cur_code_next  = r_cur_code;
    w_sample_next    = r_sample;
    w_strobe_next    = 1'b0;

    if (w_accept) begin
      // A trigger takes priority over a coincident tick; that tick is dropped.
      w_cur_code_next  = trig_code;
      w_note_idx_next  = 1'b0;
      w_phase_next     = '0;
      w_frame_cnt_next = '0;
      w_state_next     = PLAY;
    end else if (w_frame_tick) begin
      w_strobe_next = 1'b1;
      case (r_state)
        PLAY: begin
          // Polarity comes from the phase before this frame's increment.
          w_sample_next = r_phase[PHASE_W-1] ? w_mag_neg : w_mag;
          w_phase_next  = r_phase + w_note.inc;
          if (r_frame_cnt == (w_note.frames - CNT_W'(1))) begin
            w_frame_cnt_next = '0;
            w_state_next     = w_note.last ? IDLE : GAP;
          end else begin
            w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          w_sample_next = '0;
          if (r_frame_cnt == GAP_LAST) begin
            w_frame_cnt_next = '0;
            w_note_idx_next  = r_note_idx + 1'b1;
            w_phase_next     = '0;
            w_state_next     = PLAY;
          end else begin
            w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_sample_next = '0;
        end
      endcase
    end
  end

  assign left_out_data  = r_sample;
  assign right_out_data = r_sample;
  assign sample_strobe  = r_strobe;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Self-checking bench for sfx_tone_gen. Expected samples come from closed-form
// formulas of the tone sequence (phase = k*inc mod 2^16) and are queued as
// ready pulses are driven; a monitor queues every strobed output for comparison.
module tb_sfx_tone_gen;

  logic        system_clock = 1'b0;
  logic        reset;
  logic        ready;
  logic        trig_valid;
  logic [1:0]  trig_code;
  logic [19:0] left_out_data;
  logic [19:0] right_out_data;
  logic        sample_strobe;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [19:0] l;
    logic [19:0] r;
    logic        b;
  } obs_t;

  typedef struct packed {
    logic [19:0] s;
    logic        b;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];

  sfx_tone_gen dut (
    .system_clock   (system_clock),
    .reset          (reset),
    .ready          (ready),
    .trig_valid     (trig_valid),
    .trig_code      (trig_code),
    .left_out_data  (left_out_data),
    .right_out_data (right_out_data),
    .sample_strobe  (sample_strobe),
    .busy           (busy)
  );

  always #5 system_clock = ~system_clock;

  always @(negedge system_clock) begin
    if (sample_strobe === 1'b1)
      obs_q.push_back('{l: left_out_data, r: right_out_data, b: busy});
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Square-wave value for phase ph at frame fin of the current note.
  function automatic logic [19:0] sq(input int ph, input int fin);
    logic [31:0] p;
    logic [19:0] mag;
    p   = ph;
    mag = 20'h20000;
`ifdef SFX_DECAY_EN
    mag = mag >> (fin / 1024);
`else
    if (fin < 0) mag = 20'h0;
`endif
    return p[15] ? (20'h0 - mag) : mag;
  endfunction

  // Expected sample and post-tick busy for frame k after the effect started.
  function automatic exp_t exp_frame(input int code, input int k);
    exp_t e;
    e.s = 20'h0;
    e.b = 1'b0;
    case (code)
      1: if (k < 1920) begin
        e.s = sq((k * 1202) % 65536, k);
        e.b = (k < 1919);
      end
      2: if (k < 1440) begin
        e.s = sq((k * 1802) % 65536, k);
        e.b = (k < 1439);
      end
      3: begin
        if (k < 5760) begin
          e.s = sq((k * 601) % 65536, k);
          e.b = 1'b1;
        end else if (k < 6720) begin
          e.b = 1'b1;
        end else if (k < 12480) begin
          e.s = sq(((k - 6720) * 300) % 65536, k - 6720);
          e.b = (k < 12479);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // One AC97 frame: ready high for one cycle, low for two. Starts and ends on a negedge.
  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge system_clock);
    ready = 1'b0;
    @(negedge system_clock);
    @(negedge system_clock);
  endtask

  task automatic play_frames(input int code, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      exp_q.push_back(exp_frame(code, k));
      pulse_ready();
    end
  endtask

  task automatic trigger(input logic [1:0] code);
    $display("trigger code=%0d busy=%b", code, busy);
    trig_valid = 1'b1;
    trig_code  = code;
    @(negedge system_clock);
    trig_valid = 1'b0;
    trig_code  = 2'd0;
  endtask

  task automatic test_reset();
    int n;
    obs_t o;
    exp_t e;
    reset      = 1'b1;
    ready      = 1'b0;
    trig_valid = 1'b0;
    trig_code  = 2'd0;
    repeat (4) @(negedge system_clock);
    total++;
    if ({left_out_data, right_out_data, sample_strobe, busy} !== 42'h0) begin
      bad++;
      $display("FAIL reset_state got=%h/%h/%b/%b want=0/0/0/0",
               left_out_data, right_out_data, sample_strobe, busy);
    end
    reset = 1'b0;
    @(negedge system_clock);
    // Latency: strobe must appear on the third cycle after ready rises.
    exp_q.push_back('{s: 20'h0, b: 1'b0});
    ready = 1'b1;
    @(negedge system_clock);
    ready = 1'b0;
    total++;
    if (sample_strobe !== 1'b0) begin
      bad++;
      $display("FAIL latency_c1 got=%b want=0", sample_strobe);
    end
    @(negedge system_clock);
    total++;
    if (sample_strobe !== 1'b0) begin
      bad++;
      $display("FAIL latency_c2 got=%b want=0", sample_strobe);
    end
    @(negedge system_clock);
    total++;
    if (sample_strobe !== 1'b1) begin
      bad++;
      $display("FAIL latency_c3 got=%b want=1", sample_strobe);
    end
    play_frames(0, 0, 4);
    @(negedge system_clock);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL idle_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.l !== e.s || o.r !== e.s || o.b !== e.b) begin
        bad++;
        $display("FAIL idle_sample idx=%0d got l=%h r=%h busy=%b want s=%h busy=%b",
                 n, o.l, o.r, o.b, e.s, e.b);
      end
      n++;
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_reset done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_ignore_zero();
    trigger(2'd0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL code0_ignored got=%b want=0", busy);
    end
  endtask

  task automatic test_paddle();
    int n;
    obs_t o;
    exp_t e;
    trigger(2'd1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL paddle_busy got=%b want=1", busy);
    end
    play_frames(1, 0, 1922);
    @(negedge system_clock);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL paddle_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.l !== e.s || o.r !== e.s || o.b !== e.b) begin
        bad++;
        $display("FAIL paddle_sample idx=%0d got l=%h r=%h busy=%b want s=%h busy=%b",
                 n, o.l, o.r, o.b, e.s, e.b);
      end
      n++;
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_paddle done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_life();
    int n;
    obs_t o;
    exp_t e;
    trigger(2'd3);
    play_frames(3, 0, 200);
    // Lower and equal codes must not disturb the running effect.
    trigger(2'd1);
    trigger(2'd3);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL life_busy_after_drop got=%b want=1", busy);
    end
    play_frames(3, 200, 12482 - 200);
    @(negedge system_clock);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL life_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.l !== e.s || o.r !== e.s || o.b !== e.b) begin
        bad++;
        $display("FAIL life_sample idx=%0d got l=%h r=%h busy=%b want s=%h busy=%b",
                 n, o.l, o.r, o.b, e.s, e.b);
      end
      n++;
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_life done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_preempt();
    int n;
    obs_t o;
    exp_t e;
    trigger(2'd1);
    play_frames(1, 0, 100);
    trigger(2'd2);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL preempt_busy got=%b want=1", busy);
    end
    play_frames(2, 0, 1442);
    @(negedge system_clock);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL preempt_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.l !== e.s || o.r !== e.s || o.b !== e.b) begin
        bad++;
        $display("FAIL preempt_sample idx=%0d got l=%h r=%h busy=%b want s=%h busy=%b",
                 n, o.l, o.r, o.b, e.s, e.b);
      end
      n++;
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_preempt done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_coincident_and_reset();
    int n;
    obs_t o;
    exp_t e;
    // Place the trigger in the same cycle as the frame tick.
    ready = 1'b1;
    @(negedge system_clock);
    ready = 1'b0;
    @(negedge system_clock);
    $display("trigger code=2 coincident with frame tick");
    trig_valid = 1'b1;
    trig_code  = 2'd2;
    @(negedge system_clock);
    trig_valid = 1'b0;
    trig_code  = 2'd0;
    total++;
    if (sample_strobe !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL coincident_tick got strobe=%b busy=%b want strobe=0 busy=1",
               sample_strobe, busy);
    end
    play_frames(2, 0, 50);
    @(negedge system_clock);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL coincident_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.l !== e.s || o.r !== e.s || o.b !== e.b) begin
        bad++;
        $display("FAIL coincident_sample idx=%0d got l=%h r=%h busy=%b want s=%h busy=%b",
                 n, o.l, o.r, o.b, e.s, e.b);
      end
      n++;
    end
    obs_q.delete();
    exp_q.delete();
    // Reset in the middle of the note.
    $display("reset mid-note out=%h busy=%b", left_out_data, busy);
    reset = 1'b1;
    @(negedge system_clock);
    total++;
    if (left_out_data !== 20'h0 || right_out_data !== 20'h0 || busy !== 1'b0 ||
        sample_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_note got=%h/%h busy=%b strobe=%b want=0/0 busy=0 strobe=0",
               left_out_data, right_out_data, busy, sample_strobe);
    end
    reset = 1'b0;
    @(negedge system_clock);
    play_frames(0, 0, 2);
    @(negedge system_clock);
    total++;
    if (obs_q.size() !== 2) begin
      bad++;
      $display("FAIL post_reset_count got=%0d want=2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.l !== e.s || o.r !== e.s || o.b !== e.b) begin
        bad++;
        $display("FAIL post_reset_sample got l=%h r=%h busy=%b want s=%h busy=%b",
                 o.l, o.r, o.b, e.s, e.b);
      end
    end
    obs_q.delete();
    exp_q.delete();
    $display("test_coincident_and_reset done total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_ignore_zero();
    test_paddle();
    test_life();
    test_preempt();
    test_coincident_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
